// File: rtl/quadrature_decoder.sv
// quadrature_decoder: synchronizes and filters quadrature A/B lines, decodes Gray-code steps into pulses and a position count
module quadrature_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_in,
  input  logic                 b_in,
  input  logic                 clear,
  input  logic                 err_clr,
  output logic                 step_cw,
  output logic                 step_ccw,
  output logic                 dir,
  output logic [CNT_WIDTH-1:0] position,
  output logic                 err,
  output logic                 tracking
);
  typedef enum logic {UNPRIMED, TRACKING} state_t;
  localparam logic [7:0] FC = FILTER_CYCLES[7:0];
  state_t state;
  logic [SYNC_STAGES-1:0] a_sync, b_sync;
  logic [1:0] s, ab_f, cand, p_old, p_new, d;
  logic [7:0] cnt, obs;
  logic acc, cw, ccw, bad, prime;
  assign s = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};
  assign tracking = (state == TRACKING);
  // Filter bookkeeping and step decode; phase index runs 0..3 along the clockwise sequence so the
  // modulo-4 difference classifies a step as +1 (cw), -1 (ccw) or 2 (diagonal)
  always_comb begin
    obs   = (s == cand) ? cnt + 8'd1 : 8'd1;
    p_old = {ab_f[0], ab_f[1] ^ ab_f[0]};
    p_new = {s[0], s[1] ^ s[0]};
    d     = p_new - p_old;
    acc   = (state == TRACKING) && (s != ab_f) && (obs == FC);
    cw    = acc && (d == 2'd1);
    ccw   = acc && (d == 2'd3);
    bad   = acc && (d == 2'd2);
    prime = (state == UNPRIMED) && (obs == FC);
  end
  // Input synchronizer chains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], a_in};
      b_sync <= {b_sync[SYNC_STAGES-2:0], b_in};
    end
  end
  // Stability filter, priming FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNPRIMED;
      ab_f     <= '0;
      cand     <= '0;
      cnt      <= '0;
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      dir      <= 1'b0;
      position <= '0;
      err      <= 1'b0;
    end else begin
      cand     <= s;
      step_cw  <= cw;
      step_ccw <= ccw;
      err      <= bad | (err & ~err_clr);
      position <= clear ? '0 : position + {{(CNT_WIDTH-1){ccw}}, cw | ccw};
      if (cw) dir <= 1'b1;
      else if (ccw) dir <= 1'b0;
      if (s == ab_f) begin
        cnt <= (state == UNPRIMED && !prime) ? obs : 8'd0;
        if (prime) state <= TRACKING;
      end else if (obs == FC) begin
        cnt   <= 8'd0;
        ab_f  <= s;
        state <= TRACKING;
      end else begin
        cnt <= obs;
      end
    end
  end
endmodule

// File: tb/tb_quadrature_decoder.sv
// tb_quadrature_decoder: directed scoreboard bench for quadrature_decoder
module tb_quadrature_decoder;
  logic clk = 0, rst_n = 0, a_in = 0, b_in = 0, clear = 0, err_clr = 0;
  logic step_cw, step_ccw, dir, err, tracking;
  logic [15:0] position;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {int at; logic cw; logic [15:0] pos;} exp_t;
  exp_t q[$];

  quadrature_decoder dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .clear(clear), .err_clr(err_clr),
    .step_cw(step_cw), .step_ccw(step_ccw), .dir(dir), .position(position), .err(err), .tracking(tracking)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest expected step in cycle, direction and position
  always @(negedge clk) begin
    if (rst_n && (step_cw || step_ccw)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: cw=%b ccw=%b pos=%h at cycle %0d, none expected", step_cw, step_ccw, position, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.at);
        chk("pulse_kind", {step_cw, step_ccw}, {e.cw, ~e.cw});
        chk("pulse_pos", position, e.pos);
        chk("pulse_dir", dir, e.cw);
      end
    end
  end

  // Drive a new AB value (aligned 1 time unit after an edge) and hold it; kind 1=cw, 2=ccw expected
  task automatic step(input logic a, input logic b, input int hold, input int kind, input logic [15:0] pos);
    exp_t e;
    a_in = a;
    b_in = b;
    if (kind != 0) begin
      e.at = cyc + 6;
      e.cw = (kind == 1);
      e.pos = pos;
      q.push_back(e);
    end
    repeat (hold) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tracking", tracking, 0);
    chk("rst_pos", position, 0);
    chk("rst_steps", {step_cw, step_ccw}, 0);
    chk("rst_err_dir", {err, dir}, 0);
    rst_n = 1;
    // 1: prime on stable 00, then four clockwise steps
    repeat (20) @(posedge clk);
    #1;
    chk("t1_tracking", tracking, 1);
    step(1, 0, 10, 1, 16'd1);
    step(1, 1, 10, 1, 16'd2);
    step(0, 1, 10, 1, 16'd3);
    step(0, 0, 10, 1, 16'd4);
    chk("t1_pos", position, 4);
    chk("t1_dir", dir, 1);
    chk("t1_err", err, 0);
    // 2: clear, then five counter-clockwise steps
    clear = 1;
    @(posedge clk);
    #1;
    clear = 0;
    chk("t2_clear", position, 0);
    step(0, 1, 10, 2, 16'hFFFF);
    step(1, 1, 10, 2, 16'hFFFE);
    step(1, 0, 10, 2, 16'hFFFD);
    step(0, 0, 10, 2, 16'hFFFC);
    step(0, 1, 10, 2, 16'hFFFB);
    chk("t2_pos", position, 16'hFFFB);
    chk("t2_dir", dir, 0);
    // 3: back to 00, short glitch filtered, then real cw and ccw
    step(0, 0, 10, 1, 16'hFFFC);
    step(1, 0, 3, 0, 0);
    step(0, 0, 10, 0, 0);
    chk("t3_glitch", position, 16'hFFFC);
    step(1, 0, 10, 1, 16'hFFFD);
    step(0, 0, 10, 2, 16'hFFFC);
    chk("t3_pos", position, 16'hFFFC);
    // 4: diagonal 00->11 sets err, normal step follows, err_clr clears
    step(1, 1, 10, 0, 0);
    chk("t4_err", err, 1);
    chk("t4_pos", position, 16'hFFFC);
    step(0, 1, 10, 1, 16'hFFFD);
    err_clr = 1;
    @(posedge clk);
    #1;
    err_clr = 0;
    chk("t4_errclr", err, 0);
    // diagonal 01->10 with err_clr on the accepting edge: set wins
    a_in = 1;
    b_in = 0;
    repeat (5) @(posedge clk);
    #1;
    err_clr = 1;
    @(posedge clk);
    #1;
    err_clr = 0;
    chk("t4_setwins", err, 1);
    repeat (4) @(posedge clk);
    #1;
    // 5: reset mid-operation, release with AB=11
    rst_n = 0;
    a_in = 1;
    b_in = 1;
    #1;
    chk("t5_async_rst", {tracking, err, position}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_not_yet", tracking, 0);
    @(posedge clk);
    #1;
    chk("t5_tracking", tracking, 1);
    chk("t5_err", err, 0);
    repeat (4) @(posedge clk);
    #1;
    step(0, 1, 10, 1, 16'd1);
    // 6: down to FFFF, wrap up to 0, then clear coincident with a cw step
    step(1, 1, 10, 2, 16'd0);
    step(1, 0, 10, 2, 16'hFFFF);
    step(1, 1, 10, 1, 16'd0);
    chk("t6_wrap", position, 0);
    step(0, 1, 10, 1, 16'd1);
    begin
      exp_t e;
      a_in = 0;
      b_in = 0;
      e.at = cyc + 6;
      e.cw = 1;
      e.pos = 0;
      q.push_back(e);
      repeat (5) @(posedge clk);
      #1;
      clear = 1;
      @(posedge clk);
      #1;
      clear = 0;
    end
    chk("t6_clear_pos", position, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("pending_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
